fetch_queue: RTL and testbench

Instruction fetch stage placed directly upstream of the decode/execute core. It owns the fetch PC, issues reads to the synchronous instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. Control-flow redirects (branch, call, ret) flush the buffer and squash in-flight reads. A fetched HLT (opcode 4'hF) stops further fetching until the next redirect.

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues synchronous instruction-memory
// reads and buffers returned words with their PCs in a small FIFO for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_rd_en,
    output logic [15:0] im_addr,
    input  logic [15:0] im_data,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        fetch_halted
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam int                 CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [3:0]         OP_HLT  = 4'hF;

    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [15:0]      inflight_pc_q, inflight_pc_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [15:0] data_mem [DEPTH];
    logic [15:0] pc_mem   [DEPTH];

    logic issue, enq, deq;

    assign instr_valid  = (count_q != '0);
    assign instr        = instr_valid ? data_mem[rd_ptr_q] : 16'h0000;
    assign instr_pc     = instr_valid ? pc_mem[rd_ptr_q]   : 16'h0000;
    assign im_rd_en     = issue;
    assign im_addr      = fetch_pc_q;
    assign fetch_halted = halted_q;

    // Counting the in-flight read against capacity is what makes overflow impossible.
    always_comb begin
        issue = !halted_q && !redirect_valid && ((count_q + CNT_W'(inflight_q)) < DEPTH_C);
        enq   = inflight_q && !halted_q && !redirect_valid;
        deq   = instr_valid && instr_ready && !redirect_valid;
    end

    // NOTE: every *_d gets a default from its *_q first, so no path leaves it unassigned (no latch).
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            halted_d   = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'h0001;
            end else begin
                inflight_d = 1'b0;
            end

            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (im_data[15:12] == OP_HLT) begin
                    halted_d = 1'b1;
                end
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0000;
            halted_q      <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q == 0 masks stale contents from the outputs.
    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[wr_ptr_q] <= im_data;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        im_rd_en;
    logic [15:0] im_addr;
    logic [15:0] im_data = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        fetch_halted;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .im_rd_en(im_rd_en), .im_addr(im_addr), .im_data(im_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the request.
    logic [15:0] imem [65536];
    always @(posedge clk) begin
        if (im_rd_en) im_data <= imem[im_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {pc, word}, the fetch PC, one outstanding read, halt flag.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc = RESET_PC;
    logic [15:0] m_inf_pc = 16'h0000;
    bit          m_inf = 1'b0;
    bit          m_halt = 1'b0;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          e_rd;
        logic [15:0] e_addr;
        bit          e_v;
        logic [15:0] e_ins;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tab[$];
    vec_t nov;

    task automatic add(input bit rst, input bit rdy, input bit e_rd, input logic [15:0] e_addr,
                       input bit e_v, input logic [15:0] e_ins, input logic [15:0] e_pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_v = e_v; v.e_ins = e_ins; v.e_pc = e_pc;
        tab.push_back(v);
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input bit rst, input bit rdr, input logic [15:0] rpc, input bit rdy,
                        input bit use_tab, input vec_t v);
        bit          e_rd, e_v, nh;
        logic [15:0] e_ins, e_pc;
        ent_t        e;
        @(negedge clk);
        rst_n = rst; redirect_valid = rdr; redirect_pc = rpc; instr_ready = rdy;
        #1;
        e_rd  = !m_halt && !rdr && ((mq.size() + int'(m_inf)) < DEPTH);
        e_v   = (mq.size() != 0);
        e_ins = e_v ? mq[0].ins : 16'h0000;
        e_pc  = e_v ? mq[0].pc  : 16'h0000;
        if (rst) begin
            if (use_tab) begin
                check("tab_im_rd_en", im_rd_en, v.e_rd);
                check("tab_im_addr", im_addr, v.e_addr);
                check("tab_instr_valid", instr_valid, v.e_v);
                check("tab_instr", instr, v.e_ins);
                check("tab_instr_pc", instr_pc, v.e_pc);
                check("tab_fetch_halted", fetch_halted, 16'h0000);
            end else begin
                check("im_rd_en", im_rd_en, e_rd);
                check("im_addr", im_addr, m_pc);
                check("instr_valid", instr_valid, e_v);
                check("instr", instr, e_ins);
                check("instr_pc", instr_pc, e_pc);
                check("fetch_halted", fetch_halted, m_halt);
            end
        end
        if (!rst) begin
            mq.delete(); m_pc = RESET_PC; m_inf = 0; m_halt = 0;
        end else if (rdr) begin
            mq.delete(); m_pc = rpc; m_inf = 0; m_halt = 0;
        end else begin
            nh = m_halt;
            if (e_v && rdy) void'(mq.pop_front());
            if (m_inf && !m_halt) begin
                e.pc = m_inf_pc; e.ins = im_data;
                mq.push_back(e);
                if (im_data[15:12] == 4'hF) nh = 1;
            end
            if (e_rd) begin
                m_inf = 1; m_inf_pc = m_pc; m_pc = m_pc + 16'h0001;
            end else begin
                m_inf = 0;
            end
            m_halt = nh;
        end
    endtask

    task automatic cyc(input bit rdr, input logic [15:0] rpc, input bit rdy);
        step(1'b1, rdr, rpc, rdy, 1'b0, nov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_k, old_seen, got;
        bit          ok, saw5, saw6, rd6, late_rd;
        logic [15:0] wrap_pcs [3];

        for (int i = 0; i < 65536; i++) imem[i] = 16'h1000 + 16'(i);

        // Straight-line fetch, mid-operation reset, then backpressure and release.
        add(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(1, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000);
        add(1, 1, 1, 16'h0002, 1, 16'h1000, 16'h0000);
        add(1, 1, 1, 16'h0003, 1, 16'h1001, 16'h0001);
        add(1, 1, 1, 16'h0004, 1, 16'h1002, 16'h0002);
        add(1, 1, 1, 16'h0005, 1, 16'h1003, 16'h0003);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(1, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(1, 0, 1, 16'h0001, 0, 16'h0000, 16'h0000);
        add(1, 0, 1, 16'h0002, 1, 16'h1000, 16'h0000);
        add(1, 0, 1, 16'h0003, 1, 16'h1000, 16'h0000);
        add(1, 0, 0, 16'h0004, 1, 16'h1000, 16'h0000);
        add(1, 0, 0, 16'h0004, 1, 16'h1000, 16'h0000);
        add(1, 1, 0, 16'h0004, 1, 16'h1000, 16'h0000);
        add(1, 1, 1, 16'h0004, 1, 16'h1001, 16'h0001);
        add(1, 1, 1, 16'h0005, 1, 16'h1002, 16'h0002);
        add(1, 1, 1, 16'h0006, 1, 16'h1003, 16'h0003);
        add(1, 1, 1, 16'h0007, 1, 16'h1004, 16'h0004);

        foreach (tab[i]) step(tab[i].rst, 1'b0, 16'h0000, tab[i].rdy, 1'b1, tab[i]);

        // Redirect with three entries queued and a read in flight.
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (mq.size() == DEPTH - 1 && m_inf) begin ok = 1; break; end
            cyc(1'b0, 16'h0000, 1'b0);
        end
        check("rdr_setup_reached", 16'(ok), 16'h0001);
        cyc(1'b1, 16'h0040, 1'b1);
        first_k = -1; old_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 16'h0000, 1'b1);
            if (k == 1) begin
                check("rdr_next_valid", 16'(instr_valid), 16'h0000);
                check("rdr_next_addr", im_addr, 16'h0040);
            end
            if (instr_valid && first_k < 0) first_k = k;
            if (instr_valid && instr_pc < 16'h0040) old_seen++;
        end
        check("rdr_first_valid_cycle", 16'(first_k), 16'h0003);
        check("rdr_old_pc_seen", 16'(old_seen), 16'h0000);

        // HLT at PC 5 stops fetch after the PC 6 read; PC 6 never delivered.
        imem[5] = 16'hF000;
        cyc(1'b1, 16'h0000, 1'b1);
        saw5 = 0; saw6 = 0; rd6 = 0; late_rd = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 16'h0000, 1'b1);
            if (rd6 && im_rd_en) late_rd = 1;
            if (im_rd_en && im_addr == 16'h0006) rd6 = 1;
            if (instr_valid && instr_pc == 16'h0005 && instr == 16'hF000) saw5 = 1;
            if (instr_valid && instr_pc == 16'h0006) saw6 = 1;
        end
        check("hlt_pc5_delivered", 16'(saw5), 16'h0001);
        check("hlt_pc6_read", 16'(rd6), 16'h0001);
        check("hlt_read_after_pc6", 16'(late_rd), 16'h0000);
        check("hlt_pc6_delivered", 16'(saw6), 16'h0000);
        check("hlt_fetch_halted", 16'(fetch_halted), 16'h0001);
        cyc(1'b1, 16'h0010, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);
        check("hlt_cleared", 16'(fetch_halted), 16'h0000);
        check("hlt_resume_rd", 16'(im_rd_en), 16'h0001);
        check("hlt_resume_addr", im_addr, 16'h0010);
        imem[5] = 16'h1005;
        for (int k = 0; k < 5; k++) cyc(1'b0, 16'h0000, 1'b1);

        // PC wrap from 16'hFFFE.
        cyc(1'b1, 16'hFFFE, 1'b1);
        got = 0;
        for (int i = 0; i < 3; i++) wrap_pcs[i] = 16'hDEAD;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 16'h0000, 1'b1);
            if (instr_valid && got < 3) begin wrap_pcs[got] = instr_pc; got++; end
        end
        check("wrap_pc0", wrap_pcs[0], 16'hFFFE);
        check("wrap_pc1", wrap_pcs[1], 16'hFFFF);
        check("wrap_pc2", wrap_pcs[2], 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 512; i++)
            imem[i] = ($urandom_range(0, 15) == 0) ? {4'hF, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
        for (int k = 0; k < 400; k++) begin
            bit rst_b, rdr_b, rdy_b;
            rst_b = ($urandom_range(0, 99) != 0);
            rdr_b = ($urandom_range(0, 19) == 0);
            rdy_b = ($urandom_range(0, 9) < 7);
            step(rst_b, rdr_b, 16'($urandom_range(0, 400)), rdy_b, 1'b0, nov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
